snn_spike_decoder: RTL and testbench

Downstream stage of the SNN core: consumes the per-timestep `digit_spikes` vector, counts spikes per output neuron over a programmable window of timesteps, then selects the winning digit (argmax) and presents it on a valid/ready result port. Sits between the network's output layer and the APB-readable result path or a scoreboard.

---
 rtl/snn_spike_decoder.sv | 151 +++++++++++++++
 tb/tb_snn_spike_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/snn_spike_decoder.sv
// Spike-count decoder: counts output-layer spikes per class over a window, then argmax.
// Latency: result_valid rises OUTPUT_SIZE+1 cycles after the last counted strobe.
// Backpressure: result held in DONE until result_ready; start/spike_valid ignored while busy.
// Optional: define SNN_DECODER_MARGIN_EN to add result_margin (winner minus runner-up).
module snn_spike_decoder #(
  parameter int OUTPUT_SIZE = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int IDX_WIDTH   = $clog2(OUTPUT_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            window_len,
  input  logic                   spike_valid,
  input  logic [OUTPUT_SIZE-1:0] digit_spikes,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IDX_WIDTH-1:0]   result_class,
  output logic [CNT_WIDTH-1:0]   result_count,
`ifdef SNN_DECODER_MARGIN_EN
  output logic [CNT_WIDTH-1:0]   result_margin,
`endif
  output logic                   no_spike
);

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            len_q;
  logic [15:0]            ts_q;
  logic [CNT_WIDTH-1:0]   cnt_q [OUTPUT_SIZE];
  logic [IDX_WIDTH-1:0]   scan_q;
  logic [CNT_WIDTH-1:0]   best_cnt_q;
  logic [IDX_WIDTH-1:0]   best_idx_q;

  logic                   last_step;
  logic                   scan_last;
  logic [CNT_WIDTH-1:0]   cur_cnt;
  logic                   take;
  logic [CNT_WIDTH-1:0]   best_cnt_n;
  logic [IDX_WIDTH-1:0]   best_idx_n;

`ifdef SNN_DECODER_MARGIN_EN
  logic [CNT_WIDTH-1:0]   second_q;
  logic [CNT_WIDTH-1:0]   second_n;
`endif

  // Scan datapath: select the class under inspection and compute the updated running best.
  always_comb begin
    last_step = spike_valid && ((ts_q + 16'd1) == len_q);
    scan_last = (scan_q == IDX_WIDTH'(OUTPUT_SIZE - 1));
    cur_cnt   = '0;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      if (scan_q == IDX_WIDTH'(i)) cur_cnt = cnt_q[i];
    end
    // Strictly-greater replacement keeps ties on the lowest index.
    take       = (cur_cnt > best_cnt_q);
    best_cnt_n = take ? cur_cnt : best_cnt_q;
    best_idx_n = take ? scan_q  : best_idx_q;
`ifdef SNN_DECODER_MARGIN_EN
    // Runner-up: displaced best, or a non-winning count above the current runner-up
    // (an equal-to-best count lands here, which is what makes ties give margin 0).
    if (take)                  second_n = best_cnt_q;
    else if (cur_cnt > second_q) second_n = cur_cnt;
    else                       second_n = second_q;
`endif
  end

  // Next-state logic for the window / scan / hold sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                        state_d = ACCUM;
      ACCUM:   if (last_step)                    state_d = ARGMAX;
      ARGMAX:  if (scan_last)                    state_d = DONE;
      DONE:    if (result_valid && result_ready) state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d != IDLE);
      result_valid <= (state_d == DONE);
    end
  end

  // Window bookkeeping and saturating per-class spike counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= 16'd1;
      ts_q  <= '0;
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt_q[i] <= '0;
    end else if (state_q == IDLE && start) begin
      len_q <= (window_len == 16'd0) ? 16'd1 : window_len;
      ts_q  <= '0;
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt_q[i] <= '0;
    end else if (state_q == ACCUM && spike_valid) begin
      ts_q <= ts_q + 16'd1;
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        if (digit_spikes[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  // Argmax scan, one class per cycle; results captured on the final comparison and held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q        <= '0;
      best_cnt_q    <= '0;
      best_idx_q    <= '0;
      result_class  <= '0;
      result_count  <= '0;
      no_spike      <= 1'b0;
`ifdef SNN_DECODER_MARGIN_EN
      second_q      <= '0;
      result_margin <= '0;
`endif
    end else if (state_q == IDLE && start) begin
      scan_q     <= '0;
      best_cnt_q <= '0;
      best_idx_q <= '0;
`ifdef SNN_DECODER_MARGIN_EN
      second_q   <= '0;
`endif
    end else if (state_q == ARGMAX) begin
      scan_q     <= scan_q + 1'b1;
      best_cnt_q <= best_cnt_n;
      best_idx_q <= best_idx_n;
`ifdef SNN_DECODER_MARGIN_EN
      second_q   <= second_n;
`endif
      if (scan_last) begin
        result_class  <= best_idx_n;
        result_count  <= best_cnt_n;
        no_spike      <= (best_cnt_n == '0);
`ifdef SNN_DECODER_MARGIN_EN
        result_margin <= best_cnt_n - second_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Directed bench for snn_spike_decoder: vector table of windows plus hand-written
// sequences for reset mid-window, held result under backpressure and one-cycle DONE.
module tb_snn_spike_decoder;
  localparam int OS = 10;
  localparam int CW = 8;
  localparam int IW = $clog2(OS);

  logic          clk;
  logic          rst;
  logic          start;
  logic [15:0]   window_len;
  logic          spike_valid;
  logic [OS-1:0] digit_spikes;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] result_class;
  logic [CW-1:0] result_count;
  logic          no_spike;
`ifdef SNN_DECODER_MARGIN_EN
  logic [CW-1:0] result_margin;
`endif

  snn_spike_decoder #(.OUTPUT_SIZE(OS), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .window_len   (window_len),
    .spike_valid  (spike_valid),
    .digit_spikes (digit_spikes),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_count (result_count),
`ifdef SNN_DECODER_MARGIN_EN
    .result_margin(result_margin),
`endif
    .no_spike     (no_spike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0]   win;
    logic [OS-1:0] pe;     // spikes on even timesteps
    logic [OS-1:0] po;     // spikes on odd timesteps
    int            steps;
    int            cls;
    int            cnt;
    int            ns;
    int            mgn;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] w);
    start      = 1'b1;
    window_len = w;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Strobes with an idle cycle (all spike bits set) between them; no gap after the last.
  task automatic feed(input logic [OS-1:0] pe, input logic [OS-1:0] po, input int n);
    for (int i = 0; i < n; i++) begin
      spike_valid  = 1'b1;
      digit_spikes = (i % 2 == 0) ? pe : po;
      @(posedge clk); #1;
      spike_valid  = 1'b0;
      if (i != n - 1) begin
        digit_spikes = '1;
        @(posedge clk); #1;
      end
    end
    digit_spikes = '0;
  endtask

  // Cycles from the last strobe cycle to the first cycle with result_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!result_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("valid_after_hs", result_valid, 0);
    check("busy_after_hs", busy, 0);
  endtask

  initial begin
    int lat;
    logic [IW-1:0] hold_cls;
    logic [CW-1:0] hold_cnt;

    vt[0] = '{win: 16'd5,   pe: 10'h008, po: 10'h008, steps: 5,   cls: 3, cnt: 5,   ns: 0, mgn: 5};
    vt[1] = '{win: 16'd4,   pe: 10'h084, po: 10'h084, steps: 4,   cls: 2, cnt: 4,   ns: 0, mgn: 0};
    vt[2] = '{win: 16'd300, pe: 10'h200, po: 10'h200, steps: 300, cls: 9, cnt: 255, ns: 0, mgn: 255};
    vt[3] = '{win: 16'd0,   pe: 10'h000, po: 10'h000, steps: 1,   cls: 0, cnt: 0,   ns: 1, mgn: 0};
    vt[4] = '{win: 16'd6,   pe: 10'h3FF, po: 10'h3FF, steps: 6,   cls: 0, cnt: 6,   ns: 0, mgn: 0};
    vt[5] = '{win: 16'd4,   pe: 10'h022, po: 10'h020, steps: 4,   cls: 5, cnt: 4,   ns: 0, mgn: 2};

    rst = 1'b1; start = 1'b0; window_len = '0; spike_valid = 1'b0;
    digit_spikes = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_class", result_class, 0);
    check("rst_count", result_count, 0);
    check("rst_no_spike", no_spike, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Strobes while idle must not start anything.
    spike_valid = 1'b1; digit_spikes = '1;
    repeat (3) @(posedge clk);
    #1;
    spike_valid = 1'b0; digit_spikes = '0;
    check("idle_strobe_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      do_start(vt[v].win);
      feed(vt[v].pe, vt[v].po, vt[v].steps);
      check("busy_in_argmax", busy, 1);
      wait_valid(lat);
      check("latency", lat, OS + 1);
      check("class", result_class, vt[v].cls);
      check("count", result_count, vt[v].cnt);
      check("no_spike", no_spike, vt[v].ns);
`ifdef SNN_DECODER_MARGIN_EN
      check("margin", result_margin, vt[v].mgn);
`endif
      handshake();
    end

    // Reset in the middle of a window discards it.
    do_start(16'd8);
    feed(10'h3FF, 10'h3FF, 3);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", result_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(16'd2);
    feed(10'h002, 10'h002, 2);
    wait_valid(lat);
    check("midrst_latency", lat, OS + 1);
    check("midrst_class", result_class, 1);
    check("midrst_count", result_count, 2);
    handshake();

    // Result held under backpressure while start/spike_valid toggle.
    do_start(16'd3);
    feed(10'h010, 10'h010, 3);
    wait_valid(lat);
    hold_cls = result_class;
    hold_cnt = result_count;
    check("hold_class_init", hold_cls, 4);
    check("hold_count_init", hold_cnt, 3);
    for (int i = 0; i < 10; i++) begin
      start        = (i % 2 == 0);
      spike_valid  = (i % 2 == 1);
      digit_spikes = '1;
      @(posedge clk); #1;
      check("hold_valid", result_valid, 1);
      check("hold_class", result_class, 4);
      check("hold_count", result_count, 3);
    end
    start = 1'b0; spike_valid = 1'b0; digit_spikes = '0;
    handshake();

    // Start on the idle cycle right after the handshake, with ready already high.
    do_start(16'd1);
    result_ready = 1'b1;
    feed(10'h000, 10'h000, 1);
    wait_valid(lat);
    check("early_ready_latency", lat, OS + 1);
    check("early_ready_no_spike", no_spike, 1);
    check("early_ready_class", result_class, 0);
    @(posedge clk); #1;
    check("one_cycle_done_valid", result_valid, 0);
    check("one_cycle_done_busy", busy, 0);
    result_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
